// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared slice width and sequencer state type
package adder_pkg;
  localparam int SLICE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/RippleCarryAdder.sv
// rtl/RippleCarryAdder.sv - 8-bit gate-level ripple-carry adder slice
module RippleCarryAdder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] sum
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];
endmodule

// File: rtl/serial_word_adder_ctrl.sv
// rtl/serial_word_adder_ctrl.sv - WIDTH-bit add/sub sequenced over one 8-bit adder slice
module serial_word_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NS = WIDTH / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0 || SLICE != SLICE_W) begin : g_bad_width
    $error("serial_word_adder_ctrl: WIDTH must be a positive multiple of 8 and SLICE must be 8");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             a_msb;
  logic             beff_msb;

  logic [7:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;
  logic             last_slice;

  RippleCarryAdder u_slice (
    .a    (a_sh[7:0]),
    .b    (b_sh[7:0]),
    .cin  (carry),
    .cout (slice_cout),
    .sum  (slice_sum)
  );

  // New slice enters at the top so that after NS shifts the word is in place.
  assign sum_next   = (sum_sh >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));
  assign last_slice = (cnt == CW'(NS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      a_msb     <= 1'b0;
      beff_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_sub ? ~in_b : in_b;
            carry    <= in_sub ? 1'b1 : in_cin;
            a_msb    <= in_a[WIDTH-1];
            beff_msb <= in_sub ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          sum_sh <= sum_next;
          carry  <= slice_cout;
          cnt    <= cnt + CW'(1);
          if (last_slice) begin
            out_sum   <= sum_next;
            out_cout  <= slice_cout;
            out_ovf   <= (a_msb == beff_msb) && (slice_sum[7] != a_msb);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_adder_ctrl.sv
// tb/tb_serial_word_adder_ctrl.sv - scoreboard bench for the serial word adder sequencer
module tb_serial_word_adder_ctrl;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic         in_cin;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  serial_word_adder_ctrl #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    res_t         r;
    logic [W:0]   t;
    logic [W-1:0] be;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return once the accept edge has passed.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, output bit ok);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    ok = in_ready;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, exp_lat);
    end
  endtask

  // Handshake the held result and compare it with the scoreboard head.
  task automatic collect(input string name);
    res_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_scoreboard_empty: size=0 required >0", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (out_sum !== e.sum) begin
      bad++;
      $display("FAIL %s_sum: got %h required %h", name, out_sum, e.sum);
    end
    total++;
    if (out_cout !== e.cout) begin
      bad++;
      $display("FAIL %s_cout: got %b required %b", name, out_cout, e.cout);
    end
    total++;
    if (out_ovf !== e.ovf) begin
      bad++;
      $display("FAIL %s_ovf: got %b required %b", name, out_ovf, e.ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input res_t exp, input string name);
    bit ok;
    sb.push_back(exp);
    start_op(a, b, sub, cin, ok);
    wait_result(4, name);
    collect(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
  endtask

  task automatic test_add();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}, "add_wrap");
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1, '{32'h0100_0101, 1'b0, 1'b0}, "carry_chain");
    run_op(32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0100, 1'b0, 1'b0}, "carry_cin");
  endtask

  task automatic test_sub();
    run_op(32'd5, 32'd7, 1'b1, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0}, "sub_borrow");
    // in_cin must be ignored for subtract
    run_op(32'd7, 32'd5, 1'b1, 1'b1, '{32'h0000_0002, 1'b1, 1'b0}, "sub_noborrow");
  endtask

  task automatic test_overflow();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}, "ovf_add");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1}, "ovf_sub");
  endtask

  task automatic test_backpressure();
    bit   ok;
    res_t e;
    e = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    sb.push_back(e);
    start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, ok);
    wait_result(4, "bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_a     = $urandom;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== e.sum) begin
        bad++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h required 1 0 %h",
                 i, out_valid, in_ready, out_sum, e.sum);
      end
    end
    in_valid = 1'b0;
    collect("bp");
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_no_accept: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int seen;
    start_op(32'hAAAA_5555, 32'h0F0F_0F0F, 1'b0, 1'b0, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b sum=%h cout=%b required 1 0 0 0",
               in_ready, out_valid, out_sum, out_cout);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrun_discard: out_valid cycles=%0d required 0", seen);
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0}, "after_reset");
  endtask

  task automatic test_back_to_back();
    bit           ok;
    int           n;
    logic [W-1:0] a2, b2;
    a2 = 32'h8000_0001;
    b2 = 32'h8000_0001;
    sb.push_back(model(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0));
    sb.push_back(model(a2, b2, 1'b0, 1'b0));
    out_ready = 1'b1;
    start_op(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, ok);
    in_valid = 1'b1;
    in_a = a2; in_b = b2; in_sub = 1'b0; in_cin = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      if (out_valid) begin
        res_t e;
        e = sb.pop_front();
        total++;
        if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
          bad++;
          $display("FAIL b2b_first: got %h/%b/%b required %h/%b/%b",
                   out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        end
      end
      tick();
      n++;
    end
    total++;
    if (n + 1 != 6) begin
      bad++;
      $display("FAIL b2b_throughput: accept spacing %0d cycles required 6", n + 1);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_result(4, "b2b_second");
    collect("b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic         s, c;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      run_op(a, b, s, c, model(a, b, s, c), "random");
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #2;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
